fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port imem_req  output  1  fetch request valid.
REQ-005 SHALL provide port imem_addr  output  32  fetch byte address, word aligned.
REQ-006 SHALL provide port imem_ready  input  1  memory accepts request this cycle.
REQ-007 SHALL provide port imem_rvalid  input  1  response valid, in request order.
REQ-008 SHALL provide port imem_rdata  input  32  response instruction word.
REQ-009 SHALL provide port pc_src_e  input  1  redirect (taken branch/jump) this cycle.
REQ-010 SHALL provide port pc_target_e  input  32  redirect target address.
REQ-011 SHALL provide port stall_d  input  1  decode cannot accept instruction.
REQ-012 SHALL provide port valid_d  output  1  instr_d/pc_d/pc_plus4_d valid.
REQ-013 SHALL provide ports instr_d, pc_d, pc_plus4_d  output  32 each  instruction, its PC, PC+4.
REQ-014 SHALL provide port misalign_f  output  1  one-cycle misaligned-target flag (macro only).

Function
REQ-015 SHALL issue a request (handshake = imem_req & imem_ready) only when outstanding + buffered < 2, so every response fits the 2-entry buffer.
REQ-016 SHALL hold imem_addr stable while imem_req high and not accepted; pc_f advances by 4 only on handshake.
REQ-017 SHALL write a non-dropped response into the buffer in its rvalid cycle; valid_d SHALL rise the following cycle (1-cycle latency when empty).
REQ-018 SHALL present buffer head on instr_d/pc_d/pc_plus4_d; pop when valid_d & !stall_d; simultaneous push and pop allowed when full.
REQ-019 SHALL drive instr_d = NOP (32'h0000_0013) and valid_d = 0 when buffer empty.
REQ-020 On pc_src_e: flush buffer, set pc_f = pc_target_e, load drop counter with current outstanding count (including a handshake in that same cycle), force imem_req low that cycle; fetch at target starts next cycle.
REQ-021 SHALL discard responses while drop counter nonzero, decrementing per response; redirect wins over simultaneous push or pop.
REQ-022 Back-to-back redirects SHALL accumulate correctly: drop counter = all still-outstanding requests.
REQ-023 Outstanding counter range 0..2; over/underflow SHALL be impossible under REQ-015.

Reset
REQ-024 On rst: pc_f = RESET_PC, buffer empty, outstanding = 0, drop = 0, valid_d = 0, instr_d = NOP, pc_d = pc_plus4_d = 0, imem_req = 0, misalign_f = 0.
REQ-025 imem_req SHALL assert in first cycle after rst deasserts; reset mid-fetch SHALL abandon outstanding requests (memory is reset with the core).

Configuration
REQ-026 Macro FETCH_MISALIGN_CHECK_EN: defined -> redirect with pc_target_e[1:0] != 0 pulses misalign_f one cycle and suspends fetching (imem_req low) until next aligned redirect; undefined -> target[1:0] forced to 0, misalign_f tied 0.

Structure
REQ-027 Shared package riscv_pkg SHALL hold XLEN (32), NOP_INSTR, default RESET_PC, FETCH_BUF_DEPTH (2).
REQ-028 SHALL instantiate one sub-module fetch_buffer (2-entry FIFO of {instr, pc}, count/full/empty, synchronous flush).

Verification
REQ-029 Reset release, imem_ready=1, rvalid 1 cycle after each handshake -> addresses 0,4,8,... ; valid_d first high cycle 3; instr_d matches rdata in order.
REQ-030 stall_d held high 5 cycles -> buffer fills to 2, imem_req stops, instr_d/pc_d stable; release -> no instruction lost or duplicated.
REQ-031 Two requests outstanding (0x10, 0x14), pc_src_e with target 0x100 -> both responses dropped, next imem_addr 0x100, pc_d first shows 0x100.
REQ-032 Redirect in same cycle as response push and decode pop -> buffer empty next cycle, valid_d = 0, response discarded.
REQ-033 imem_ready low 4 cycles -> imem_addr held constant, pc_f unchanged, valid_d falls after buffer drains.
REQ-034 Macro defined, redirect target 0x102 -> misalign_f one-cycle pulse, no requests until redirect to 0x200; macro undefined -> fetch at 0x100.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | riscv_pkg : shared core constants, fetch buffer entry type, helpers |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package riscv_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int              FETCH_BUF_DEPTH  = 2;
  localparam int              FETCH_BUF_CNT_W  = $clog2(FETCH_BUF_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_buffer : small FIFO of {instr, pc} with synchronous flush     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [FETCH_BUF_CNT_W-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (FETCH_BUF_DEPTH > 1) ? $clog2(FETCH_BUF_DEPTH) : 1;

  fetch_entry_t               mem_q [FETCH_BUF_DEPTH];
  fetch_entry_t               mem_d [FETCH_BUF_DEPTH];
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [FETCH_BUF_CNT_W-1:0] count_q, count_d;
  logic                       do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FETCH_BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FETCH_BUF_CNT_W'(FETCH_BUF_DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : instruction fetch with 2-deep buffer and redirect drop |
// | Option macro: FETCH_MISALIGN_CHECK_EN (misaligned-target trap/halt) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  input  logic            stall_d,
  output logic            valid_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            misalign_f
);

  logic [XLEN-1:0]            pc_f_q, pc_f_d;
  logic [XLEN-1:0]            resp_pc_q, resp_pc_d;
  logic [FETCH_BUF_CNT_W-1:0] outstanding_q, outstanding_d;
  logic [FETCH_BUF_CNT_W-1:0] drop_q, drop_d;

  logic [FETCH_BUF_CNT_W-1:0] buf_count;
  logic                       buf_full, buf_empty;
  fetch_entry_t               buf_head, buf_in;
  logic [FETCH_BUF_CNT_W:0]   inflight;
  logic [XLEN-1:0]            target_eff;
  logic                       fetch_hold;
  logic                       handshake, resp_keep, buf_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic suspend_q, suspend_d;
  logic misalign_q, misalign_d;
  logic target_misaligned;

  assign target_misaligned = |pc_target_e[1:0];
  assign target_eff        = pc_target_e;
  assign fetch_hold        = suspend_q;
  assign misalign_f        = misalign_q;

  // A misaligned target parks fetch until an aligned redirect arrives.
  always_comb begin
    suspend_d  = suspend_q;
    misalign_d = 1'b0;
    if (pc_src_e) begin
      suspend_d  = target_misaligned;
      misalign_d = target_misaligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      suspend_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      suspend_q  <= suspend_d;
      misalign_q <= misalign_d;
    end
  end
`else
  logic unused_target_lsbs;

  assign unused_target_lsbs = ^pc_target_e[1:0];
  assign target_eff         = {pc_target_e[XLEN-1:2], 2'b00};
  assign fetch_hold         = 1'b0;
  assign misalign_f         = 1'b0;
`endif

  // Requests already in flight count against buffer space so every response lands.
  assign inflight  = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req  = ~rst & ~pc_src_e & ~fetch_hold
                   & (inflight < (FETCH_BUF_CNT_W + 1)'(FETCH_BUF_DEPTH));
  assign imem_addr = pc_f_q;
  assign handshake = imem_req & imem_ready;

  assign resp_keep = imem_rvalid & (drop_q == '0) & ~pc_src_e;
  assign buf_pop   = valid_d & ~stall_d;
  assign buf_in    = '{instr: imem_rdata, pc: resp_pc_q};

  always_comb begin
    outstanding_d = outstanding_q;
    if (handshake && !imem_rvalid) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!handshake && imem_rvalid) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  // Responses are in order, so one running PC tags them; a redirect rebases it.
  always_comb begin
    pc_f_d    = pc_f_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;
    if (pc_src_e) begin
      pc_f_d    = target_eff;
      resp_pc_d = target_eff;
      drop_d    = outstanding_d;
    end else begin
      if (handshake) begin
        pc_f_d = pc_next(pc_f_q);
      end
      if (resp_keep) begin
        resp_pc_d = pc_next(resp_pc_q);
      end
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q        <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_f_q        <= pc_f_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (pc_src_e),
    .push       (resp_keep),
    .push_entry (buf_in),
    .pop        (buf_pop),
    .head       (buf_head),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  assign valid_d    = ~buf_empty;
  assign instr_d    = buf_empty ? NOP_INSTR : buf_head.instr;
  assign pc_d       = buf_empty ? '0 : buf_head.pc;
  assign pc_plus4_d = buf_empty ? '0 : pc_next(buf_head.pc);

  logic unused_buf_full;
  assign unused_buf_full = buf_full;

endmodule
`default_nettype wire
